// File: rtl/ds_operand_scoreboard_if.sv
// Decode-stage operand/hazard bus: issue request, bypass channels, writeback, and resolved results.
interface ds_operand_scoreboard_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3
);
  logic                    issue_valid;
  logic                    issue_ready;
  logic                    issue_fire;
  logic                    issue_gr_we;
  logic [4:0]              issue_dest;
  logic                    src1_used;
  logic                    src2_used;
  logic [4:0]              src1_addr;
  logic [4:0]              src2_addr;
  logic [XLEN-1:0]         rf_rdata1;
  logic [XLEN-1:0]         rf_rdata2;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_avail;
  logic [5*NUM_FWD-1:0]    fwd_dest;
  logic [XLEN*NUM_FWD-1:0] fwd_value;
  logic                    wb_we;
  logic [4:0]              wb_dest;
  logic [XLEN-1:0]         wb_value;
  logic                    flush;
  logic [XLEN-1:0]         src1_value;
  logic [XLEN-1:0]         src2_value;
  logic [31:0]             stall_cycles;

  modport master (
    output issue_valid, issue_fire, issue_gr_we, issue_dest,
    output src1_used, src2_used, src1_addr, src2_addr, rf_rdata1, rf_rdata2,
    output fwd_valid, fwd_avail, fwd_dest, fwd_value,
    output wb_we, wb_dest, wb_value, flush,
    input  issue_ready, src1_value, src2_value, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_fire, issue_gr_we, issue_dest,
    input  src1_used, src2_used, src1_addr, src2_addr, rf_rdata1, rf_rdata2,
    input  fwd_valid, fwd_avail, fwd_dest, fwd_value,
    input  wb_we, wb_dest, wb_value, flush,
    output issue_ready, src1_value, src2_value, stall_cycles
  );
endinterface

// File: rtl/ds_operand_scoreboard.sv
// Decode-stage operand resolution: per-register outstanding-write counters, prioritised bypass,
// writeback bypass, ready_go generation and a stall-cycle counter.
module ds_operand_scoreboard #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned CNT_W   = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  ds_operand_scoreboard_if.slave   bus
);
  localparam int unsigned NREG    = 32;
  localparam int unsigned AW      = 5;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic [CNT_W-1:0] r_cnt [NREG];
  logic [31:0]      r_stall_cycles;

  logic             w_inc;
  logic             w_dec;
  logic             w_sat_stall;
  logic             w_ready;
  logic [NREG-1:0]  w_inc_vec;
  logic [NREG-1:0]  w_dec_vec;

  logic [AW-1:0]    w_addr      [2];
  logic             w_used      [2];
  logic [XLEN-1:0]  w_rf        [2];
  logic             w_hit       [2];
  logic             w_hit_avail [2];
  logic [XLEN-1:0]  w_hit_val   [2];
  logic [XLEN-1:0]  w_val       [2];
  logic             w_haz       [2];

  assign w_inc     = bus.issue_fire && bus.issue_gr_we && (bus.issue_dest != '0);
  assign w_dec     = bus.wb_we && (bus.wb_dest != '0);
  assign w_inc_vec = w_inc ? (NREG'(1) << bus.issue_dest) : '0;
  assign w_dec_vec = w_dec ? (NREG'(1) << bus.wb_dest) : '0;

  // A same-cycle retire of the destination frees the slot the new writer needs.
  assign w_sat_stall = bus.issue_gr_we && (r_cnt[bus.issue_dest] == CNT_W'(CNT_MAX)) &&
                       !(w_dec && (bus.wb_dest == bus.issue_dest));

  always_comb begin
    w_addr[0] = bus.src1_addr;
    w_addr[1] = bus.src2_addr;
    w_used[0] = bus.src1_used;
    w_used[1] = bus.src2_used;
    w_rf[0]   = bus.rf_rdata1;
    w_rf[1]   = bus.rf_rdata2;
  end

  // Per source: youngest matching channel, then writeback, then scoreboard, then register file.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_hit[s]       = 1'b0;
      w_hit_avail[s] = 1'b0;
      w_hit_val[s]   = '0;
      w_val[s]       = '0;
      w_haz[s]       = 1'b0;
      for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
        if (bus.fwd_valid[i] && (bus.fwd_dest[i*5 +: 5] == w_addr[s])) begin
          w_hit[s]       = 1'b1;
          w_hit_avail[s] = bus.fwd_avail[i];
          w_hit_val[s]   = bus.fwd_value[i*int'(XLEN) +: XLEN];
        end
      end
      if (w_used[s] && (w_addr[s] != '0)) begin
        if (w_hit[s]) begin
          if (w_hit_avail[s]) w_val[s] = w_hit_val[s];
          else                w_haz[s] = 1'b1;
        end else if (bus.wb_we && (bus.wb_dest == w_addr[s])) begin
          w_val[s] = bus.wb_value;
        end else if (r_cnt[w_addr[s]] != '0) begin
          w_haz[s] = 1'b1;
        end else begin
          w_val[s] = w_rf[s];
        end
      end
    end
  end

  assign w_ready = !bus.flush && !w_haz[0] && !w_haz[1] && !w_sat_stall;

  // Outstanding-write counters; flush discards every in-flight writer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else if (bus.flush) begin
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (w_inc_vec[r] && !w_dec_vec[r] && (r_cnt[r] != CNT_W'(CNT_MAX)))
          r_cnt[r] <= r_cnt[r] + CNT_W'(1);
        else if (w_dec_vec[r] && !w_inc_vec[r] && (r_cnt[r] != '0))
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            r_stall_cycles <= '0;
    else if (bus.issue_valid && !w_ready)   r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign bus.issue_ready  = w_ready;
  assign bus.src1_value   = w_val[0];
  assign bus.src2_value   = w_val[1];
  assign bus.stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_ds_operand_scoreboard.sv
// Bench for ds_operand_scoreboard: directed scenarios plus randomized traffic against a
// list-search reference model with plain integer outstanding-write counts.
module tb_ds_operand_scoreboard;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NF    = 3;
  localparam int unsigned CNT_W = 2;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic clk;
  logic resetn;
  int          m_cnt [32];
  logic [31:0] m_stall;
  int          n_checks;
  int          n_fail;

  ds_operand_scoreboard_if #(.XLEN(XLEN), .NUM_FWD(NF)) bus ();

  ds_operand_scoreboard #(.XLEN(XLEN), .NUM_FWD(NF), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    bus.issue_valid = 0; bus.issue_fire = 0; bus.issue_gr_we = 0; bus.issue_dest = 0;
    bus.src1_used = 0; bus.src2_used = 0; bus.src1_addr = 0; bus.src2_addr = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
    bus.fwd_valid = 0; bus.fwd_avail = 0; bus.fwd_dest = 0; bus.fwd_value = 0;
    bus.wb_we = 0; bus.wb_dest = 0; bus.wb_value = 0; bus.flush = 0;
  endtask

  task automatic model_clear();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_stall = 0;
  endtask

  // Reference operand lookup: first matching channel in priority order, else wb, else count, else rf.
  function automatic void resolve(input logic used, input logic [4:0] addr, input logic [31:0] rf,
                                  output logic [31:0] val, output logic haz);
    val = 0;
    haz = 0;
    if (!used || addr == 0) return;
    for (int i = 0; i < NF; i++) begin
      if (bus.fwd_valid[i] && bus.fwd_dest[i*5 +: 5] == addr) begin
        if (bus.fwd_avail[i]) val = bus.fwd_value[i*XLEN +: XLEN];
        else                  haz = 1;
        return;
      end
    end
    if (bus.wb_we && bus.wb_dest == addr) val = bus.wb_value;
    else if (m_cnt[addr] != 0)            haz = 1;
    else                                  val = rf;
  endfunction

  function automatic void model_eval(output logic rdy, output logic [31:0] v1, output logic [31:0] v2);
    logic h1, h2, sat;
    resolve(bus.src1_used, bus.src1_addr, bus.rf_rdata1, v1, h1);
    resolve(bus.src2_used, bus.src2_addr, bus.rf_rdata2, v2, h2);
    sat = bus.issue_gr_we && m_cnt[bus.issue_dest] == SAT &&
          !(bus.wb_we && bus.wb_dest != 0 && bus.wb_dest == bus.issue_dest);
    rdy = !bus.flush && !h1 && !h2 && !sat;
  endfunction

  // Advance model by one cycle with the currently driven inputs, then clock the DUT.
  task automatic step();
    logic rdy;
    logic [31:0] a, b;
    model_eval(rdy, a, b);
    if (bus.issue_valid && !rdy) m_stall = m_stall + 32'd1;
    if (bus.flush) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
    end else begin
      if (bus.issue_fire && bus.issue_gr_we && bus.issue_dest != 0) m_cnt[bus.issue_dest]++;
      if (bus.wb_we && bus.wb_dest != 0) m_cnt[bus.wb_dest]--;
      foreach (m_cnt[r])
        assert (m_cnt[r] >= 0 && m_cnt[r] <= SAT) else $error("protocol violation on r%0d count %0d", r, m_cnt[r]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 0;
    idle();
    model_clear();
    bus.src1_used = 1; bus.src1_addr = 6; bus.rf_rdata1 = 32'hA5A5_A5A5;
    bus.src2_used = 1; bus.src2_addr = 0; bus.rf_rdata2 = 32'hFFFF_FFFF;
    #22;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.issue_ready); end
    n_checks++; if (bus.src1_value !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL reset_src1: got %h want a5a5a5a5", bus.src1_value); end
    n_checks++; if (bus.src2_value !== 32'h0) begin n_fail++; $display("FAIL reset_src2_r0: got %h want 0", bus.src2_value); end
    n_checks++; if (bus.stall_cycles !== 32'h0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cycles); end
    @(posedge clk);
    #1;
    resetn = 1;
    idle();
  endtask

  task automatic test_issue_forward();
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 5; bus.issue_fire = 1;
    bus.src1_used = 1; bus.src2_used = 1;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL add_r5_ready: got %b want 1", bus.issue_ready); end
    n_checks++; if (bus.src1_value !== 32'h0 || bus.src2_value !== 32'h0) begin n_fail++; $display("FAIL add_r5_src_r0: got %h/%h want 0/0", bus.src1_value, bus.src2_value); end
    step();
    bus.issue_fire = 0; bus.issue_gr_we = 0; bus.src1_addr = 5;
    bus.fwd_valid = 3'b001; bus.fwd_dest[4:0] = 5; bus.fwd_avail = 3'b001; bus.fwd_value[31:0] = 32'h1234;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ch0_ready: got %b want 1", bus.issue_ready); end
    n_checks++; if (bus.src1_value !== 32'h1234) begin n_fail++; $display("FAIL fwd_ch0_value: got %h want 1234", bus.src1_value); end
    step();
    bus.fwd_valid = 0;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_r5_stall: got %b want 0", bus.issue_ready); end
    step();
    bus.wb_we = 1; bus.wb_dest = 5; bus.wb_value = 32'h5555;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src1_value !== 32'h5555) begin n_fail++; $display("FAIL wb_r5_bypass: got %b/%h want 1/5555", bus.issue_ready, bus.src1_value); end
    step();
    idle();
  endtask

  task automatic test_load_use();
    logic [31:0] s0;
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 7; bus.issue_fire = 1;
    step();
    bus.issue_fire = 0; bus.issue_gr_we = 0; bus.src1_used = 1; bus.src1_addr = 7;
    bus.fwd_valid = 3'b001; bus.fwd_dest[4:0] = 7; bus.fwd_avail = 3'b000;
    s0 = m_stall;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_stall: got %b want 0", bus.issue_ready); end
    step();
    bus.fwd_valid = 3'b010; bus.fwd_dest = 0; bus.fwd_dest[9:5] = 7; bus.fwd_avail = 3'b010;
    bus.fwd_value[63:32] = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src1_value !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_fwd_ch1: got %b/%h want 1/deadbeef", bus.issue_ready, bus.src1_value); end
    n_checks++; if (bus.stall_cycles !== s0 + 32'd1) begin n_fail++; $display("FAIL load_stall_count: got %0d want %0d", bus.stall_cycles, s0 + 32'd1); end
    step();
    idle();
    bus.wb_we = 1; bus.wb_dest = 7;
    step();
    idle();
  endtask

  task automatic test_multicycle();
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 9; bus.issue_fire = 1;
    step();
    bus.issue_fire = 0; bus.issue_gr_we = 0; bus.src2_used = 1; bus.src2_addr = 9;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL div_r9_stall_%0d: got %b want 0", k, bus.issue_ready); end
      step();
    end
    bus.wb_we = 1; bus.wb_dest = 9; bus.wb_value = 32'h42;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src2_value !== 32'h42) begin n_fail++; $display("FAIL div_wb_bypass: got %b/%h want 1/42", bus.issue_ready, bus.src2_value); end
    step();
    bus.wb_we = 0; bus.rf_rdata2 = 32'h99;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src2_value !== 32'h99) begin n_fail++; $display("FAIL div_retired_rf: got %b/%h want 1/99", bus.issue_ready, bus.src2_value); end
    step();
    idle();
  endtask

  task automatic test_priority();
    bus.issue_valid = 1; bus.src1_used = 1; bus.src1_addr = 3;
    bus.fwd_valid = 3'b101; bus.fwd_avail = 3'b111;
    bus.fwd_dest[4:0] = 3; bus.fwd_dest[9:5] = 3; bus.fwd_dest[14:10] = 3;
    bus.fwd_value[31:0] = 32'h11; bus.fwd_value[63:32] = 32'h33; bus.fwd_value[95:64] = 32'h22;
    bus.wb_we = 1; bus.wb_dest = 3; bus.wb_value = 32'h44;
    #2;
    n_checks++; if (bus.src1_value !== 32'h11 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL prio_ch0_over_ch2: got %h/%b want 11/1", bus.src1_value, bus.issue_ready); end
    bus.fwd_valid = 3'b100;
    #2;
    n_checks++; if (bus.src1_value !== 32'h22) begin n_fail++; $display("FAIL prio_ch2_over_wb: got %h want 22", bus.src1_value); end
    bus.fwd_valid = 3'b000;
    #2;
    n_checks++; if (bus.src1_value !== 32'h44) begin n_fail++; $display("FAIL prio_wb: got %h want 44", bus.src1_value); end
    idle();
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 0; bus.issue_fire = 1;
    bus.src1_used = 1; bus.src1_addr = 0; bus.rf_rdata1 = 32'h77;
    bus.fwd_valid = 3'b001; bus.fwd_avail = 3'b001; bus.fwd_value[31:0] = 32'h55;
    bus.wb_we = 1; bus.wb_dest = 0; bus.wb_value = 32'h66;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_checks++; if (bus.issue_ready !== 1'b1 || bus.src1_value !== 32'h0) begin n_fail++; $display("FAIL r0_write_%0d: got %b/%h want 1/0", k, bus.issue_ready, bus.src1_value); end
      step();
    end
    idle();
  endtask

  task automatic test_saturation();
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 4; bus.issue_fire = 1;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_fill_%0d: got %b want 1", k, bus.issue_ready); end
      step();
    end
    bus.issue_fire = 0;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall: got %b want 0", bus.issue_ready); end
    step();
    bus.wb_we = 1; bus.wb_dest = 4;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sat_same_cycle_retire: got %b want 1", bus.issue_ready); end
    bus.issue_fire = 1;
    step();
    bus.wb_we = 0; bus.issue_fire = 0;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sat_count_held: got %b want 0", bus.issue_ready); end
    step();
    idle();
  endtask

  task automatic test_flush();
    bus.issue_valid = 1; bus.src1_used = 1; bus.src1_addr = 4; bus.rf_rdata1 = 32'h77; bus.flush = 1;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", bus.issue_ready); end
    step();
    bus.flush = 0;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src1_value !== 32'h77) begin n_fail++; $display("FAIL post_flush_rf: got %b/%h want 1/77", bus.issue_ready, bus.src1_value); end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    bus.issue_valid = 1; bus.issue_gr_we = 1; bus.issue_dest = 10; bus.issue_fire = 1;
    step();
    bus.issue_fire = 0; bus.issue_gr_we = 0; bus.src1_used = 1; bus.src1_addr = 10; bus.rf_rdata1 = 32'hABCD;
    #2;
    n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL pre_reset_stall: got %b want 0", bus.issue_ready); end
    step();
    #1;
    resetn = 0;
    #1;
    model_clear();
    n_checks++; if (bus.stall_cycles !== 32'h0) begin n_fail++; $display("FAIL async_reset_stall: got %0d want 0", bus.stall_cycles); end
    n_checks++; if (bus.issue_ready !== 1'b1 || bus.src1_value !== 32'hABCD) begin n_fail++; $display("FAIL async_reset_cnt: got %b/%h want 1/abcd", bus.issue_ready, bus.src1_value); end
    #1;
    resetn = 1;
    step();
    idle();
  endtask

  task automatic test_random();
    logic er;
    logic [31:0] e1, e2;
    int r;
    for (int c = 0; c < 400; c++) begin
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_gr_we = 1'($urandom_range(0, 1));
      bus.issue_dest  = 5'($urandom_range(0, 7));
      bus.src1_used   = 1'($urandom_range(0, 1));
      bus.src2_used   = 1'($urandom_range(0, 1));
      bus.src1_addr   = 5'($urandom_range(0, 7));
      bus.src2_addr   = 5'($urandom_range(0, 7));
      bus.rf_rdata1   = $urandom;
      bus.rf_rdata2   = $urandom;
      bus.fwd_valid   = NF'($urandom);
      bus.fwd_avail   = NF'($urandom);
      for (int i = 0; i < NF; i++) begin
        bus.fwd_dest[i*5 +: 5]        = 5'($urandom_range(0, 7));
        bus.fwd_value[i*XLEN +: XLEN] = $urandom;
      end
      r = $urandom_range(1, 7);
      bus.wb_we    = (m_cnt[r] > 0) && ($urandom_range(0, 1) == 1);
      bus.wb_dest  = bus.wb_we ? 5'(r) : 5'($urandom_range(0, 7));
      bus.wb_value = $urandom;
      bus.flush    = ($urandom_range(0, 15) == 0);
      model_eval(er, e1, e2);
      bus.issue_fire = bus.issue_valid && er && ($urandom_range(0, 1) == 1);
      #2;
      n_checks++; if (bus.issue_ready !== er) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.issue_ready, er); end
      if (er) begin
        n_checks++; if (bus.src1_value !== e1) begin n_fail++; $display("FAIL rnd_src1 c%0d: got %h want %h", c, bus.src1_value, e1); end
        n_checks++; if (bus.src2_value !== e2) begin n_fail++; $display("FAIL rnd_src2 c%0d: got %h want %h", c, bus.src2_value, e2); end
      end
      n_checks++; if (bus.stall_cycles !== m_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, bus.stall_cycles, m_stall); end
      step();
    end
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_issue_forward();
    test_load_use();
    test_multicycle();
    test_priority();
    test_saturation();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
